// File: rtl/word_arith_checker_pkg.sv
// Shared types and constants for the word-arithmetic checker.
// Imported by the checker top and its sequential divider.
package word_arith_pkg;

  localparam int WORD_W    = 8;
  localparam int DIV_CONST = 3;
  localparam int SUB_CONST = 2;
  localparam int CNT_W     = 9;
  localparam int DIV_STEPS = 8;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    PREP,
    DIVQ,
    DIVR,
    CMP,
    DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/word_arith_checker_seq_divu8.sv
// Restoring shift-subtract unsigned 8/8 divider.
// One load cycle, then DIV_STEPS iterate cycles; results valid with done.
module seq_divu8
  import word_arith_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] dividend,
  input  logic [WORD_W-1:0] divisor,
  output logic              done,
  output logic [WORD_W-1:0] quotient,
  output logic [WORD_W-1:0] remainder
);

  logic [WORD_W-1:0] rem_q;
  logic [WORD_W-1:0] quo_q;
  logic [WORD_W-1:0] den_q;
  logic [2:0]        cnt_q;
  logic              run_q;

  logic [WORD_W:0]   trial;
  logic [WORD_W:0]   diff;
  logic              ge;
  logic [WORD_W-1:0] rem_n;
  logic [WORD_W-1:0] quo_n;

  // The final step is combinational so results match the done cycle.
  always_comb begin
    trial = {rem_q, quo_q[WORD_W-1]};
    diff  = trial - {1'b0, den_q};
    ge    = (trial >= {1'b0, den_q});
    rem_n = ge ? diff[WORD_W-1:0] : trial[WORD_W-1:0];
    quo_n = {quo_q[WORD_W-2:0], ge};
  end

  assign done      = run_q && (cnt_q == 3'(DIV_STEPS - 1));
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      den_q <= divisor;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + 3'd1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/word_arith_checker.sv
// Sweeps x over [X_FIRST, X_LAST], compares the block's response
// against a golden ((((x+1)^2)(x-2))/3)%(x+1) from a shared divider.
module word_arith_checker
  import word_arith_pkg::*;
#(
  parameter int X_FIRST = 0,
  parameter int X_LAST  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WORD_W-1:0] dut_in,
  input  logic [WORD_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  skip_count,
  output logic              first_err_valid,
  output logic [WORD_W-1:0] first_err_in,
  output logic [WORD_W-1:0] first_err_exp,
  output logic [WORD_W-1:0] first_err_got
);

  state_t state;
  state_t state_nxt;

  logic [WORD_W-1:0] x;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] got;
  logic [WORD_W-1:0] exp_w;
  logic              skip;
  logic [WORD_W-1:0] div_n;
  logic [WORD_W-1:0] div_d;
  logic              div_go;

  logic              div_done;
  logic [WORD_W-1:0] div_q;
  logic [WORD_W-1:0] div_r;

  logic [WORD_W-1:0] a_c;
  logic [WORD_W-1:0] sq_c;
  logic [WORD_W-1:0] p_c;
  logic              accept;
  logic              last;
  logic              mism;

  always_comb begin
    a_c    = x + 8'd1;
    sq_c   = a_c * a_c;
    p_c    = sq_c * (x - 8'(SUB_CONST));
    accept = start && (state == IDLE || state == DONE);
    last   = (x == 8'(X_LAST));
    mism   = !skip && (got != exp_w);
  end

  seq_divu8 u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_go),
    .dividend  (div_n),
    .divisor   (div_d),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = APPLY;
      end
      APPLY: begin
        busy      = 1'b1;
        state_nxt = PREP;
      end
      PREP: begin
        busy      = 1'b1;
        state_nxt = DIVQ;
      end
      DIVQ: begin
        busy = 1'b1;
        if (div_done) state_nxt = (a == '0) ? CMP : DIVR;
      end
      DIVR: begin
        busy = 1'b1;
        if (div_done) state_nxt = CMP;
      end
      CMP: begin
        busy      = 1'b1;
        state_nxt = last ? DONE : APPLY;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = APPLY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dut_in = x;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x               <= '0;
      a               <= '0;
      got             <= '0;
      exp_w           <= '0;
      skip            <= 1'b0;
      div_n           <= '0;
      div_d           <= '0;
      div_go          <= 1'b0;
      err_count       <= '0;
      skip_count      <= '0;
      first_err_valid <= 1'b0;
      first_err_in    <= '0;
      first_err_exp   <= '0;
      first_err_got   <= '0;
    end else begin
      div_go <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            x               <= 8'(X_FIRST);
            skip            <= 1'b0;
            err_count       <= '0;
            skip_count      <= '0;
            first_err_valid <= 1'b0;
            first_err_in    <= '0;
            first_err_exp   <= '0;
            first_err_got   <= '0;
          end
        end
        APPLY: got <= dut_out;
        PREP: begin
          a      <= a_c;
          div_n  <= p_c;
          div_d  <= 8'(DIV_CONST);
          div_go <= 1'b1;
        end
        DIVQ: begin
          // a==0 only for x=255; the second division is never issued.
          if (div_done) begin
            if (a == '0) begin
              skip <= 1'b1;
            end else begin
              div_n  <= div_q;
              div_d  <= a;
              div_go <= 1'b1;
            end
          end
        end
        DIVR: begin
          if (div_done) exp_w <= div_r;
        end
        CMP: begin
          unique case (1'b1)
            skip: skip_count <= sat_inc(skip_count);
            mism: begin
              err_count <= sat_inc(err_count);
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_in    <= x;
                first_err_exp   <= exp_w;
                first_err_got   <= got;
              end
            end
            default: ;
          endcase
          skip <= 1'b0;
          if (!last) x <= x + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_word_arith_checker.sv
// Directed bench: four checker instances with different sweeps and
// DUT-side response models, checked against hand-computed values.
module tb_word_arith_checker;
  import word_arith_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  localparam int XF[4] = '{0, 7, 0, 255};
  localparam int XL[4] = '{255, 7, 10, 255};

  logic       start [4];
  logic [7:0] din   [4];
  logic [7:0] dout  [4];
  logic       busy  [4];
  logic       done  [4];
  logic [8:0] errc  [4];
  logic [8:0] skc   [4];
  logic       fev   [4];
  logic [7:0] fei   [4];
  logic [7:0] fex   [4];
  logic [7:0] fgo   [4];

  int n_pass = 0;
  int n_tot  = 0;

  function automatic logic [7:0] ideal(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] q;
    a = x + 8'd1;
    p = a * a * (x - 8'd2);
    q = p / 8'd3;
    return (a == 8'd0) ? 8'd0 : q % a;
  endfunction

  function automatic logic [7:0] small_tab(input logic [7:0] x);
    case (x)
      8'd3, 8'd4: return 8'd1;
      8'd6, 8'd9: return 8'd2;
      8'd7:       return 8'd5;
      8'd8:       return 8'd4;
      8'd0, 8'd1, 8'd2, 8'd5, 8'd10: return 8'd0;
      default:    return 8'hFF;
    endcase
  endfunction

  assign dout[0] = ideal(din[0]);
  assign dout[1] = (din[1] == 8'd7) ? 8'd0 : ideal(din[1]);
  assign dout[2] = small_tab(din[2]);
  assign dout[3] = 8'hA5;

  for (genvar g = 0; g < 4; g++) begin : g_chk
    word_arith_checker #(
      .X_FIRST(XF[g]),
      .X_LAST (XL[g])
    ) u_chk (
      .clk             (clk),
      .rst             (rst),
      .start           (start[g]),
      .dut_in          (din[g]),
      .dut_out         (dout[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .err_count       (errc[g]),
      .skip_count      (skc[g]),
      .first_err_valid (fev[g]),
      .first_err_in    (fei[g]),
      .first_err_exp   (fex[g]),
      .first_err_got   (fgo[g])
    );
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_done(input int k, input int exp_cyc,
                           input string tag);
    int cyc;
    cyc = 1;
    while (!done[k] && cyc < 6000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".done_cyc"}, cyc, exp_cyc);
    chk({tag, ".busy_end"}, int'(busy[k]), 0);
  endtask

  task automatic run(input int k, input bit hold, input int exp_cyc,
                     input string tag);
    @(negedge clk);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start[k] = 1'b0;
    chk({tag, ".busy1"}, int'(busy[k]), 1);
    wait_done(k, exp_cyc, tag);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < 4; k++) start[k] = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst.ctl", int'({busy[k], done[k], fev[k], din[k]}), 0);
      chk("rst.cnt", int'({errc[k], skc[k]}), 0);
      chk("rst.ferr", int'({fei[k], fex[k], fgo[k]}), 0);
    end
    @(negedge clk);
    rst = 1'b1;

    run(0, 1'b0, 5368, "full");
    chk("full.err", int'(errc[0]), 0);
    chk("full.skip", int'(skc[0]), 1);
    chk("full.fev", int'(fev[0]), 0);

    run(1, 1'b1, 22, "x7");
    chk("x7.err", int'(errc[1]), 1);
    chk("x7.skip", int'(skc[1]), 0);
    chk("x7.fev", int'(fev[1]), 1);
    chk("x7.fin", int'(fei[1]), 7);
    chk("x7.fexp", int'(fex[1]), 5);
    chk("x7.fgot", int'(fgo[1]), 0);
    @(posedge clk);
    #1;
    chk("hold.busy", int'(busy[1]), 1);
    chk("hold.done", int'(done[1]), 0);
    chk("hold.errclr", int'(errc[1]), 0);
    chk("hold.fevclr", int'(fev[1]), 0);
    start[1] = 1'b0;
    wait_done(1, 22, "hold");
    chk("hold.err", int'(errc[1]), 1);
    chk("hold.fin", int'(fei[1]), 7);
    repeat (3) @(posedge clk);
    #1;
    chk("hold.stay", int'(done[1]), 1);

    run(2, 1'b0, 232, "small");
    chk("small.err", int'(errc[2]), 0);
    chk("small.skip", int'(skc[2]), 0);

    @(negedge clk);
    start[2] = 1'b1;
    @(posedge clk);
    #1;
    start[2] = 1'b0;
    cyc = 1;
    while (cyc < 68) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid.state", int'(g_chk[2].u_chk.state), int'(DIVQ));
    chk("mid.din", int'(din[2]), 3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mid.idle", int'(g_chk[2].u_chk.state), int'(IDLE));
    chk("mid.ctl", int'({busy[2], done[2], fev[2], din[2]}), 0);
    chk("mid.cnt", int'({errc[2], skc[2]}), 0);
    chk("mid.ferr", int'({fei[2], fex[2], fgo[2]}), 0);
    run(2, 1'b0, 232, "rerun");
    chk("rerun.err", int'(errc[2]), 0);

    run(3, 1'b0, 13, "x255");
    chk("x255.skip", int'(skc[3]), 1);
    chk("x255.err", int'(errc[3]), 0);
    chk("x255.fev", int'(fev[3]), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/word_arith_checker.md
# word_arith_checker

Sequential stimulus/check companion for the combinational word-arithmetic stream block, which maps an 8-bit input x to ((((x+1)**2)·(x−2))/3) % (x+1) in 8-bit wrap-around arithmetic. The checker drives `__in0` of that block and reads `__out0` back. It computes the expected word with a multi-cycle golden model built on one shared iterative divider, and accumulates mismatch statistics. It sits beside the block in the integration/self-test wrapper, one word per compare slot.

## Interface
Parameters:
- X_FIRST, 0, first input word driven (0..255).
- X_LAST, 255, last input word driven; must satisfy X_LAST ≥ X_FIRST.

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  level; sampled only in IDLE or DONE; begins a sweep.
- dut_in  out  8  word driven to the checked block's `__in0`.
- dut_out  in  8  checked block's `__out0`; combinational response to `dut_in`.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  high in DONE; held until the next accepted start or reset.
- err_count  out  9  number of mismatching compared words.
- skip_count  out  9  number of words not compared because the divisor is zero.
- first_err_valid  out  1  set at the first mismatch of a sweep.
- first_err_in / first_err_exp / first_err_got  out  8 each  x, expected word and DUT word at the first mismatch.

## Operation
- FSM states: IDLE, APPLY, PREP, DIVQ, DIVR, CMP, DONE.
- IDLE/DONE → APPLY when start=1:
  - clears all counters and first_err_*;
  - sets x=X_FIRST.
- APPLY: `dut_in`=x (registered; valid from this cycle). Captures `dut_out` into `got` at the end of the cycle.
- PREP computes, all mod 256:
  - a=x+1;
  - p=(a·a)·(x−2).
  - It then loads the divider with dividend p and divisor 3.
- DIVQ waits for the divider; q=quotient. Then:
  - if a==0, go to CMP with skip flagged;
  - otherwise load the divider with dividend q and divisor a.
- DIVR waits for the divider; exp=remainder.
- CMP takes one of three paths:
  - skip flagged: skip_count++;
  - got≠exp: err_count++, and on the first mismatch latch first_err_* and set first_err_valid;
  - then, if x==X_LAST go to DONE, else x++ and go to APPLY.
- `start` is ignored while busy.
- Division by zero never reaches the divider.

## Timing
- Reset value of every output: 0, with state IDLE. Any cycle with rst=0, including mid-sweep, returns to IDLE with all outputs 0 on the next edge.
- The divider takes 1 load cycle plus 8 iterate cycles. Its done pulse arrives in the 8th iterate cycle, and the quotient/remainder are valid in that same cycle.
- Per word: APPLY 1 + PREP 1 + DIVQ 9 + DIVR 9 + CMP 1 = 21 cycles. A skipped word takes 12 cycles.
- Sweep from a start accepted at edge 0:
  - busy=1 from cycle 1;
  - done=1 and busy=0 in cycle N·21+1, with N=X_LAST−X_FIRST+1, minus 9 if x=255 is included.
- `dut_out` is sampled exactly once per word, at the end of APPLY. `dut_in` holds x until the next APPLY.
- Counters saturate at 511.

## Structure
- Package word_arith_pkg:
  - state enum type;
  - WORD_W=8, DIV_CONST=3, SUB_CONST=2, CNT_W=9, DIV_STEPS=8.
- Sub-module seq_divu8: restoring shift-subtract unsigned 8/8 divider.
  - Ports: clk, rst, load, dividend, divisor, done, quotient, remainder.
  - Instantiated once and reused for both divisions.

## Test plan
- Ideal DUT model, full sweep 0..255:
  - done at cycle 5368;
  - err_count=0, skip_count=1, first_err_valid=0.
- X_FIRST=X_LAST=7, DUT returns 0 at x=7 (expected 5):
  - err_count=1, first_err_in=7, first_err_exp=5, first_err_got=0;
  - done at cycle 22.
- X_FIRST=0, X_LAST=10, ideal DUT:
  - expected words include x=0→0, x=5→0, x=7→5, x=10→0;
  - err_count=0, done at cycle 232.
- Reset pulse (rst=0 for 1 cycle) during DIVQ of x=3:
  - next cycle all outputs 0, state IDLE, `dut_in`=0;
  - a following start re-runs from X_FIRST.
- start held high through a sweep and into DONE: no restart while busy. With start still high in DONE, exactly one new sweep begins, and its counters are cleared.
- X_FIRST=X_LAST=255: skip_count=1, err_count=0 regardless of `dut_out`; done at cycle 13.
